// File: rtl/cfg_stream_loader.sv
// Loads a configuration frame from a host AXI-stream into a CLB bitstream port.
// The frame is serialised LSB slice first, then the loader waits for the CLB to confirm before entering run mode.
`timescale 1ns/1ps
module cfg_stream_loader #(
  parameter int IN_WIDTH     = 8,
  parameter int OUT_WIDTH    = 1,
  parameter int FRAME_BITS   = 64,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 cfg,
  input  logic                 cfg_ready,
  output logic                 run,
  output logic                 error
);

  localparam int SLICES = IN_WIDTH / OUT_WIDTH;
  localparam int WORDS  = FRAME_BITS / IN_WIDTH;
  localparam int BW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int WW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW     = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERR} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [BW-1:0]       beat_cnt;
  logic [WW-1:0]       word_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                final_word;

  logic fire, last_slice, accept, is_final, bad_word;

  assign fire       = m_valid & m_ready;
  assign last_slice = (beat_cnt == BW'(SLICES - 1));
  // A new word may enter as the previous word's last slice leaves, so a steady stream has no bubbles.
  assign s_ready    = (state == LOAD) && !final_word && (!m_valid || (m_ready && last_slice));
  assign accept     = s_valid & s_ready;
  assign is_final   = (word_cnt == WW'(WORDS - 1));
  assign bad_word   = (s_last != is_final);
  assign m_data     = shreg[OUT_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // NOTE: the shift register is reset too, because m_data is driven straight from it.
      shreg      <= '0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      final_word <= 1'b0;
      m_valid    <= 1'b0;
      cfg        <= 1'b0;
      run        <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            final_word <= 1'b0;
            m_valid    <= 1'b0;
            cfg        <= 1'b1;
            run        <= 1'b0;
            error      <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (bad_word) begin
              // A misplaced s_last aborts the frame; the offending word is dropped.
              state   <= ERR;
              error   <= 1'b1;
              cfg     <= 1'b0;
              m_valid <= 1'b0;
            end else begin
              shreg      <= s_data;
              m_valid    <= 1'b1;
              beat_cnt   <= '0;
              word_cnt   <= word_cnt + 1'b1;
              final_word <= is_final;
            end
          end else if (fire) begin
            if (last_slice) begin
              m_valid <= 1'b0;
              if (final_word) begin
                state   <= DRAIN;
                tmo_cnt <= '0;
              end
            end else begin
              shreg    <= shreg >> OUT_WIDTH;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cfg_ready) begin
            state <= RUN;
            cfg   <= 1'b0;
            run   <= 1'b1;
          end else if (tmo_cnt == TW'(DONE_TIMEOUT - 1)) begin
            state <= ERR;
            cfg   <= 1'b0;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader: table-driven frame scenarios with a bit scoreboard,
// plus hand-written reset-mid-frame and restart-from-RUN sequences.
`timescale 1ns/1ps
module tb_cfg_stream_loader;

  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 1;
  localparam int WORDS     = 8;
  localparam int SLICES    = IN_WIDTH / OUT_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst, start, s_valid, s_last, m_ready, cfg_ready;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_ready, m_valid, cfg, run, error;
  logic [OUT_WIDTH-1:0] m_data;

  cfg_stream_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .cfg(cfg), .cfg_ready(cfg_ready), .run(run), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats_seen = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit sb_en = 1'b1;
  bit toggle = 1'b0;
  logic [OUT_WIDTH-1:0] q[$];

  typedef struct {
    int last_idx;    // word index carrying s_last (8 = never asserted)
    bit tog;         // m_ready toggles every cycle
    bit tmo;         // hold cfg_ready low until timeout
    int rdy_delay;   // cycles in DRAIN before cfg_ready
    int exp_beats;
    int exp_span;
  } case_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle) m_ready = ~m_ready;
  end

  // Beat monitor: samples on the falling edge, compares each beat against the scoreboard.
  initial begin : monitor
    bit prev_stall = 1'b0;
    logic [OUT_WIDTH-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid_hold", m_valid, 1);
        check("stall_data_hold", m_data, prev_data);
      end
      if (m_valid && m_ready && !rst) begin
        beats_seen++;
        if (beats_seen == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (sb_en) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got beat %0d data %0h, expected no beat", beats_seen, m_data);
          end else begin
            check("beat_data", m_data, q.pop_front());
          end
        end
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data  = m_data;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_case(input case_t c);
    bit got, bad;
    logic [IN_WIDTH-1:0] w;
    q.delete();
    beats_seen = 0;
    cfg_ready  = 1'b0;
    m_ready    = 1'b1;
    toggle     = c.tog;
    pulse_start();
    check("start_cfg", cfg, 1);
    check("start_run", run, 0);
    check("start_error", error, 0);
    check("start_m_valid", m_valid, 0);

    for (int k = 0; k < WORDS; k++) begin
      w       = IN_WIDTH'(k + 1);
      s_data  = w;
      s_last  = (k == c.last_idx);
      s_valid = 1'b1;
      bad     = ((k == c.last_idx) != (k == WORDS - 1));
      got     = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (s_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      if (!bad)
        for (int j = 0; j < SLICES; j++) q.push_back(OUT_WIDTH'(w >> (j * OUT_WIDTH)));
      @(posedge clk);
      #1;
      if (bad) break;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    if (c.last_idx != WORDS - 1) begin
      check("err_flag", error, 1);
      check("err_cfg", cfg, 0);
      check("err_run", run, 0);
      check("err_m_valid", m_valid, 0);
      repeat (4) @(posedge clk);
      #1;
      check("err_beats", beats_seen, c.exp_beats);
      check("err_span", last_cyc - first_cyc + 1, c.exp_span);
      check("err_s_ready", s_ready, 0);
      check("err_sb_empty", q.size(), 0);
      check("err_still_set", error, 1);
      toggle  = 1'b0;
      m_ready = 1'b1;
      return;
    end

    for (int t = 0; t < 400 && beats_seen < c.exp_beats; t++) begin
      @(posedge clk);
      #1;
    end
    check("frame_beats", beats_seen, c.exp_beats);
    check("frame_span", last_cyc - first_cyc + 1, c.exp_span);
    check("frame_sb_empty", q.size(), 0);
    check("drain_cfg", cfg, 1);
    check("drain_m_valid", m_valid, 0);
    toggle  = 1'b0;
    m_ready = 1'b1;

    if (c.tmo) begin
      repeat (15) @(posedge clk);
      #1;
      check("tmo_not_yet", error, 0);
      check("tmo_cfg_before", cfg, 1);
      @(posedge clk);
      #1;
      check("tmo_error", error, 1);
      check("tmo_cfg", cfg, 0);
      check("tmo_run", run, 0);
      repeat (3) @(posedge clk);
      #1;
      check("tmo_cfg_in_err", cfg, 0);
    end else begin
      repeat (c.rdy_delay) @(posedge clk);
      #1;
      check("drain_wait_run", run, 0);
      cfg_ready = 1'b1;
      @(posedge clk);
      #1;
      cfg_ready = 1'b0;
      check("run_set", run, 1);
      check("run_cfg", cfg, 0);
      check("run_error", error, 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    case_t cases[6];
    int b;
    cases[0] = '{last_idx: 7, tog: 1'b0, tmo: 1'b0, rdy_delay: 0, exp_beats: 64, exp_span: 64};
    cases[1] = '{last_idx: 7, tog: 1'b1, tmo: 1'b0, rdy_delay: 2, exp_beats: 64, exp_span: 127};
    cases[2] = '{last_idx: 4, tog: 1'b0, tmo: 1'b0, rdy_delay: 0, exp_beats: 32, exp_span: 32};
    cases[3] = '{last_idx: 7, tog: 1'b0, tmo: 1'b1, rdy_delay: 0, exp_beats: 64, exp_span: 64};
    cases[4] = '{last_idx: 7, tog: 1'b1, tmo: 1'b0, rdy_delay: 5, exp_beats: 64, exp_span: 127};
    cases[5] = '{last_idx: 8, tog: 1'b0, tmo: 1'b0, rdy_delay: 0, exp_beats: 56, exp_span: 56};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1; cfg_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_cfg", cfg, 0);
    check("rst_run", run, 0);
    check("rst_error", error, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cfg", cfg, 0);
    check("idle_s_ready", s_ready, 0);

    foreach (cases[i]) run_case(cases[i]);

    // Reset mid-frame: partial word discarded, nothing emitted until a new start.
    sb_en = 1'b0;
    beats_seen = 0;
    m_ready = 1'b1;
    pulse_start();
    s_data = 8'hA5; s_last = 1'b0; s_valid = 1'b1;
    for (int t = 0; t < 200 && beats_seen < 20; t++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_beats", beats_seen, 20);
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_cfg", cfg, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_s_ready", s_ready, 0);
    rst = 1'b0;
    b = beats_seen;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_beats", beats_seen, b);
    check("post_rst_m_valid", m_valid, 0);
    sb_en = 1'b1;

    run_case(cases[0]);
    // Second consecutive frame from RUN.
    run_case(cases[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
